// File: rtl/spi_channel_router.sv
// SPI minion front end: deserialises addressed frames, checks parity,
// routes payloads into per-channel FIFOs and returns a status word.
module spi_channel_router #(
  parameter int DATA_W = 16,
  parameter int NCH    = 4,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic [NCH*DATA_W-1:0] ch_msg,
  output logic [NCH-1:0]        ch_val,
  input  logic [NCH-1:0]        ch_rdy,
  output logic                  parity_err,
  output logic                  err_any
);

  localparam int AW = $clog2(NCH);
  localparam int F  = AW + DATA_W + 1;
  localparam int CW = $clog2(F + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int QW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FL = CW'(F);

  logic [1:0] cs_sy;
  logic [1:0] sclk_sy;
  logic [1:0] mosi_sy;
  logic       cs_q;
  logic       sclk_q;
  logic       cs_s;
  logic       sclk_s;
  logic       mosi_s;
  logic       cs_fall;
  logic       cs_rise;
  logic       sclk_rise;
  logic       sclk_fall;

  logic          active;
  logic [CW-1:0] cnt;
  logic [F-1:0]  rx;
  logic [F-1:0]  tx;
  logic [F-1:0]  status;
  logic          done;

  logic par;
  logic adr;
  logic ovf;
  logic shrt;

  logic [AW-1:0]     fr_addr;
  logic [DATA_W-1:0] fr_data;
  logic              bad_par;
  logic              bad_adr;
  logic              ok;
  logic              ovf_set;
  logic              short_set;

  logic [NCH-1:0] hit;
  logic [NCH-1:0] full;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] push;

  logic [DATA_W-1:0] mem [NCH][DEPTH];
  logic [PW-1:0]     wp [NCH];
  logic [PW-1:0]     rp [NCH];
  logic [QW-1:0]     fcnt [NCH];

  // Pin synchronizers track the pins through reset, so a frame
  // already in flight is never mistaken for a fresh cs fall.
  always_ff @(posedge clk) begin
    cs_sy   <= {cs_sy[0], cs};
    sclk_sy <= {sclk_sy[0], sclk};
    mosi_sy <= {mosi_sy[0], mosi};
    cs_q    <= cs_sy[1];
    sclk_q  <= sclk_sy[1];
  end

  assign cs_s      = cs_sy[1];
  assign sclk_s    = sclk_sy[1];
  assign mosi_s    = mosi_sy[1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;

  // Status word snapshot loaded into tx at frame start.
  always_comb begin
    status = '0;
    status[F-1] = par;
    status[F-2] = adr;
    status[F-3] = ovf;
    status[F-4] = shrt;
    status[F-5 -: NCH] = full;
  end

  // Frame shifter: bit counter, rx/tx shift registers, registered miso.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      rx     <= '0;
      tx     <= '0;
      done   <= 1'b0;
      miso   <= 1'b0;
    end else begin
      done <= 1'b0;
      miso <= ~cs_s & tx[F-1];
      if (cs_fall) begin
        active <= 1'b1;
        cnt    <= '0;
        tx     <= status;
      end else if (cs_rise) begin
        active <= 1'b0;
      end else if (active) begin
        if (sclk_rise && cnt < FL) begin
          rx   <= {rx[F-2:0], mosi_s};
          cnt  <= cnt + CW'(1);
          done <= (cnt == FL - CW'(1));
        end
        if (sclk_fall) begin
          tx <= {tx[F-2:0], 1'b0};
        end
      end
    end
  end

  assign fr_addr   = rx[F-1 -: AW];
  assign fr_data   = rx[DATA_W:1];
  assign bad_par   = ^rx;
  assign bad_adr   = int'(fr_addr) >= NCH;
  assign ok        = done & ~bad_par & ~bad_adr;
  assign ovf_set   = ok & |(hit & full & ~pop);
  assign short_set = cs_rise & active
                   & (cnt != '0) & (cnt != FL);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign hit[i]    = ok && (int'(fr_addr) == i);
    assign full[i]   = fcnt[i] == QW'(DEPTH);
    assign ch_val[i] = fcnt[i] != '0;
    assign pop[i]    = ch_val[i] & ch_rdy[i];
    assign push[i]   = hit[i] & (~full[i] | pop[i]);
    assign ch_msg[i*DATA_W +: DATA_W] = mem[i][rp[i]];
  end

  // Sticky error flags: read-to-clear at frame start, set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      par  <= 1'b0;
      adr  <= 1'b0;
      ovf  <= 1'b0;
      shrt <= 1'b0;
    end else begin
      par  <= (par & ~cs_fall) | (done & bad_par);
      adr  <= (adr & ~cs_fall)
            | (done & ~bad_par & bad_adr);
      ovf  <= (ovf & ~cs_fall) | ovf_set;
      shrt <= (shrt & ~cs_fall) | short_set;
    end
  end

  assign parity_err = par;
  assign err_any    = par | adr | ovf | shrt;

  // Per-channel circular FIFOs; push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
        wp[i]   <= '0;
        rp[i]   <= '0;
        fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= fr_data;
          wp[i] <= wp[i] + PW'(1);
        end
        if (pop[i]) begin
          rp[i] <= rp[i] + PW'(1);
        end
        if (push[i] && !pop[i]) begin
          fcnt[i] <= fcnt[i] + QW'(1);
        end else if (!push[i] && pop[i]) begin
          fcnt[i] <= fcnt[i] - QW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_channel_router.sv
// Scoreboard bench for spi_channel_router: SPI host model drives
// frames, expected payloads are queued per channel and popped on delivery.
module tb_spi_channel_router;

  localparam int DW    = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 2;
  localparam int F     = AW + DW + 1;
  localparam int HALF  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NCH*DW-1:0] ch_msg;
  logic [NCH-1:0]    ch_val;
  logic [NCH-1:0]    ch_rdy;
  logic              parity_err;
  logic              err_any;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] exp_q [NCH][$];
  logic [F-1:0]  st;

  always #5 clk = ~clk;

  spi_channel_router #(
    .DATA_W(DW),
    .NCH(NCH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .sclk(sclk),
    .mosi(mosi),
    .miso(miso),
    .ch_msg(ch_msg),
    .ch_val(ch_val),
    .ch_rdy(ch_rdy),
    .parity_err(parity_err),
    .err_any(err_any)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [F-1:0] mk(input logic [AW-1:0] a,
                                      input logic [DW-1:0] d,
                                      input bit good);
    logic p;
    p = (^{a, d}) ^ ~good;
    return {a, d, p};
  endfunction

  // mode 0 plain, 1 latency check (ch2), 2 pop ch0 on completion,
  // 3 reset pulse after 10 bits
  task automatic send(input logic [F-1:0] fr, input int nb,
                      input int mode, output logic [F-1:0] stv);
    stv = '0;
    cs = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (mode == 3 && i == 10) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      mosi = fr[F-1-i];
      repeat (HALF) @(negedge clk);
      stv[F-1-i] = miso;
      sclk = 1'b1;
      if (i == F - 1 && (mode == 1 || mode == 2)) begin
        repeat (3) @(negedge clk);
        if (mode == 1) chk("lat_n3", ch_val, 0);
        else ch_rdy[0] = 1'b1;
        @(negedge clk);
        if (mode == 1) chk("lat_n4", ch_val, 4'b0100);
        else ch_rdy[0] = 1'b0;
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_drain();
    int tot;
    for (int k = 0; k < 100; k++) begin
      tot = 0;
      for (int i = 0; i < NCH; i++) tot += exp_q[i].size();
      if (tot == 0) break;
      @(negedge clk);
    end
    tot = 0;
    for (int i = 0; i < NCH; i++) tot += exp_q[i].size();
    chk("drain", tot, 0);
  endtask

  // Consumer side: every accepted head must match the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (ch_val[i] && ch_rdy[i]) begin
          if (exp_q[i].size() == 0)
            chk($sformatf("ch%0d_unexpected", i),
                64'(exp_q[i].size()), 64'd1);
          else
            chk($sformatf("ch%0d_data", i),
                ch_msg[i*DW +: DW], exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    cs     = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    ch_rdy = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_val", ch_val, 0);
    chk("rst_msg", ch_msg, 0);
    chk("rst_par", parity_err, 0);
    chk("rst_err", err_any, 0);

    // valid frame to channel 2
    exp_q[2].push_back(16'hA5A5);
    send(mk(2, 16'hA5A5, 1), F, 1, st);
    chk("t1_st", st[F-1 -: 8], 8'h00);
    chk("t1_val", ch_val, 4'b0100);
    chk("t1_msg", ch_msg[47:32], 16'hA5A5);
    ch_rdy = 4'b0100;
    @(negedge clk);
    ch_rdy = '0;
    chk("t1_popped", ch_val, 0);
    chk("t1_err", err_any, 0);

    // parity error
    send(mk(2, 16'hA5A5, 0), F, 0, st);
    chk("t2_par", parity_err, 1);
    chk("t2_err", err_any, 1);
    chk("t2_val", ch_val, 0);

    // overflow on channel 1
    for (int d = 1; d <= 3; d++) begin
      if (d < 3) exp_q[1].push_back(DW'(d));
      send(mk(1, DW'(d), 1), F, 0, st);
      case (d)
        1: chk("t3_st1", st[F-1 -: 8], 8'h80);
        2: chk("t3_st2", st[F-1 -: 8], 8'h00);
        default: chk("t3_st3", st[F-1 -: 8], 8'h02);
      endcase
      if (d == 1) chk("t3_par_clr", parity_err, 0);
    end
    chk("t3_err", err_any, 1);
    chk("t3_par", parity_err, 0);
    chk("t3_head", ch_msg[31:16], 16'h0001);

    // fill channel 0, then push coinciding with a pop
    exp_q[0].push_back(16'h0010);
    send(mk(0, 16'h0010, 1), F, 0, st);
    chk("t4_st_a", st[F-1 -: 8], 8'h22);
    exp_q[0].push_back(16'h0011);
    send(mk(0, 16'h0011, 1), F, 0, st);
    chk("t4_st_b", st[F-1 -: 8], 8'h02);
    exp_q[0].push_back(16'h0012);
    send(mk(0, 16'h0012, 1), F, 2, st);
    chk("t4_st_c", st[F-1 -: 8], 8'h03);
    chk("t4_err", err_any, 0);
    chk("t4_val", ch_val, 4'b0011);
    chk("t4_head", ch_msg[15:0], 16'h0011);

    // short frame, then deliver to channel 3
    send(mk(3, 16'h1234, 1), 7, 0, st);
    chk("t5_st", st[F-1 -: 7], 7'b0000001);
    chk("t5_err", err_any, 1);
    chk("t5_val", ch_val, 4'b0011);
    ch_rdy = '1;
    wait_drain();
    chk("t5_empty", ch_val, 0);
    exp_q[3].push_back(16'h1234);
    send(mk(3, 16'h1234, 1), F, 0, st);
    chk("t5_st2", st[F-1 -: 8], 8'h10);
    wait_drain();
    chk("t5_err2", err_any, 0);

    // reset mid-frame
    send(mk(1, 16'hDEAD, 1), F, 3, st);
    chk("t6_err", err_any, 0);
    chk("t6_val", ch_val, 0);
    exp_q[0].push_back(16'hBEEF);
    send(mk(0, 16'hBEEF, 1), F, 0, st);
    chk("t6_st", st[F-1 -: 8], 8'h00);
    wait_drain();
    chk("t6_err2", err_any, 0);
    chk("t6_par", parity_err, 0);
    repeat (4) @(negedge clk);
    chk("end_val", ch_val, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
